// File: rtl/sync_fifo_param.sv
// sync_fifo_param: parametrised single-clock FIFO with selectable read timing
// (registered or first-word-fall-through), occupancy count, programmable
// almost-full/almost-empty thresholds and sticky overflow/underflow flags.
//
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   wr, data_in        write request and data
//   rd                 read request (pops head word)
//   clr_err            synchronous clear of sticky error flags
//   af_level, ae_level almost-full / almost-empty thresholds
//   data_out           read data (registered, or head word in FWFT mode)
//   fifo_count         stored words, 0..DEPTH
//   fifo_full/empty, fifo_almost_full/empty   status flags
//   fifo_overflow/underflow                   sticky error flags
module sync_fifo_param #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4,
    parameter int FWFT   = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr,
    input  logic              rd,
    input  logic [DATA_W-1:0] data_in,
    input  logic              clr_err,
    input  logic [ADDR_W:0]   af_level,
    input  logic [ADDR_W:0]   ae_level,
    output logic [DATA_W-1:0] data_out,
    output logic [ADDR_W:0]   fifo_count,
    output logic              fifo_full,
    output logic              fifo_empty,
    output logic              fifo_almost_full,
    output logic              fifo_almost_empty,
    output logic              fifo_overflow,
    output logic              fifo_underflow
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W:0] FULL_CNT = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);
    localparam logic [ADDR_W:0] CNT_ONE = (ADDR_W+1)'(1);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [DATA_W-1:0] head;
    logic              wr_ok;
    logic              rd_ok;
    logic              ovf_evt;
    logic              udf_evt;

    assign fifo_full         = (fifo_count == FULL_CNT);
    assign fifo_empty        = (fifo_count == '0);
    assign fifo_almost_full  = (fifo_count >= af_level);
    assign fifo_almost_empty = (fifo_count <= ae_level);

    // A write into a full FIFO is accepted only when the same-edge read
    // frees a slot; a write into an empty FIFO never makes it readable
    // in the same cycle.
    assign wr_ok   = wr && (!fifo_full || rd);
    assign rd_ok   = rd && !fifo_empty;
    assign ovf_evt = wr && fifo_full && !rd;
    assign udf_evt = rd && fifo_empty;

    assign head = mem[rd_ptr];

    // Storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_ptr] <= data_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (wr_ok) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (rd_ok) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            unique case ({wr_ok, rd_ok})
                2'b10:   fifo_count <= fifo_count + CNT_ONE;
                2'b01:   fifo_count <= fifo_count - CNT_ONE;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // Sticky error flags; a new event on the clearing edge wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fifo_overflow  <= 1'b0;
            fifo_underflow <= 1'b0;
        end else begin
            if (ovf_evt) begin
                fifo_overflow <= 1'b1;
            end else if (clr_err) begin
                fifo_overflow <= 1'b0;
            end
            if (udf_evt) begin
                fifo_underflow <= 1'b1;
            end else if (clr_err) begin
                fifo_underflow <= 1'b0;
            end
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            assign data_out = fifo_empty ? '0 : head;
        end else begin : g_std
            logic [DATA_W-1:0] dout_q;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    dout_q <= '0;
                end else if (rd_ok) begin
                    dout_q <= head;
                end
            end
            assign data_out = dout_q;
        end
    endgenerate

endmodule
